// File: rtl/bit_serial_adder.sv
// bit_serial_adder: multi-cycle LSB-first adder around one full adder; SERIAL_SUB_EN adds a 'sub' port for a - b.
// The FA carry is registered and fed back each cycle; results update in the cycle the last bit is added.
module bit_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_next;
    logic [WIDTH-2:0] sum_sr;
    logic             carry_r, fa_sum, fa_cout, last, sub_on;

`ifdef SERIAL_SUB_EN
    assign sub_on = sub;
`else
    assign sub_on = 1'b0;
`endif

    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry_r;
    assign fa_cout  = (a_sr[0] & b_sr[0]) | (carry_r & (a_sr[0] ^ b_sr[0]));
    assign sum_next = {fa_sum, sum_sr};
    assign last     = cnt == CW'(WIDTH - 1);
    assign busy     = state == SHIFT;
    assign done     = state == DONE;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        next = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry_r  <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr    <= a;
            b_sr    <= b ^ {WIDTH{sub_on}};
            carry_r <= cin | sub_on;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_next[WIDTH-1:1];
            carry_r <= fa_cout;
            cnt     <= cnt + CW'(1);
            // On the MSB cycle carry_r is the carry into the MSB, so overflow needs no extra register.
            if (last) begin
                sum      <= sum_next;
                cout     <= fa_cout;
                overflow <= carry_r ^ fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed and random adds (and subtracts with SERIAL_SUB_EN) against a plain-arithmetic model.
module tb_bit_serial_adder;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;
    int           errors = 0, checks = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic xs, input bit mid);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        int           n;
        bb   = xs ? ~xb : xb;
        full = {1'b0, xa} + {1'b0, bb} + (W+1)'(xs ? 1'b1 : xc);
        ov   = (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]);
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
`ifdef SERIAL_SUB_EN
        sub = xs;
`endif
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("busy_first", busy, 1);
        while (!done && n < W + 10) begin
            if (n == 2) begin a = $urandom; b = $urandom; cin = ~cin; end
            start = mid && n >= 3 && n <= 10;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, W + 1);
        check("busy_at_done", busy, 0);
        check("sum", sum, full[W-1:0]);
        check("cout", cout, full[W]);
        check("overflow", overflow, ov);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("sum_hold", sum, full[W-1:0]);
        if (mid)
            repeat (3) begin
                @(negedge clk);
                check("no_second_op", {busy, done}, 0);
            end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", {busy, done, sum, cout, overflow}, 0);

        do_add(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        do_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        do_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);

        // abort a running add with reset at SHIFT cycle 10
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {busy, done, sum, cout, overflow}, 0);
        repeat (W + 3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        do_add(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
        do_add(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
        do_add(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
`endif
        repeat (20) begin
            logic xs;
`ifdef SERIAL_SUB_EN
            xs = 1'($urandom);
`else
            xs = 1'b0;
`endif
            do_add($urandom, $urandom, 1'($urandom), xs, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
